// File: rtl/sipo_8to128.sv
// rtl/sipo_8to128.sv - byte packer assembling sixteen 8-bit words into a 128-bit block
// Define SIPO_LSB_FIRST_EN to place the first byte of a block in out[7:0] instead of out[127:120].
module sipo_8to128 (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         claer,
  input  logic [7:0]   in,
  output logic         valid,
  output logic [127:0] out
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (claer) begin
      out   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (en) begin
`ifdef SIPO_LSB_FIRST_EN
      out   <= {in, out[127:8]};
`else
      out   <= {out[119:0], in};
`endif
      // cnt wraps 15->0 naturally, so the next strobe opens a new block
      cnt   <= cnt + 4'd1;
      valid <= (cnt == 4'd15);
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_8to128.sv
// tb/tb_sipo_8to128.sv - directed self-checking bench for sipo_8to128
module tb_sipo_8to128;

  logic         clk;
  logic         reset;
  logic         en;
  logic         claer;
  logic [7:0]   in;
  logic         valid;
  logic [127:0] out;

  int errors = 0;
  int checks = 0;

  sipo_8to128 dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .claer (claer),
    .in    (in),
    .valid (valid),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SIPO_LSB_FIRST_EN
  localparam logic [127:0] FULL_EXP = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] B2B_1    = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] B2B_2    = 128'h2F2E2D2C2B2A29282726252423222120;
  localparam logic [127:0] GAP5     = {40'hFFFFFFFFFF, 88'h0};
  localparam logic [127:0] GAP11    = {88'hFFFFFFFFFFFFFFFFFFFFFF, 40'h0};
`else
  localparam logic [127:0] FULL_EXP = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] B2B_1    = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] B2B_2    = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] GAP5     = {88'h0, 40'hFFFFFFFFFF};
  localparam logic [127:0] GAP11    = {40'h0, 88'hFFFFFFFFFFFFFFFFFFFFFF};
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    en = 1'b1;
    in = b;
    tick();
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check("idle_valid", {127'b0, valid}, 128'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    claer = 1'b0;
    in    = 8'h00;

    // reset held for 100 ns
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rst_out", out, 128'b0);
      check("rst_valid", {127'b0, valid}, 128'b0);
    end
    reset = 1'b0;

    // full block 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      check("full_valid", {127'b0, valid}, {127'b0, (i == 15)});
    end
    check("full_out", out, FULL_EXP);
    idle(1);
    check("full_hold", out, FULL_EXP);

    // gapped strobes of 0xFF, starting from a cleared block
    claer = 1'b1;
    tick();
    claer = 1'b0;
    check("clr_out", out, 128'b0);
    for (int i = 1; i <= 16; i++) begin
      send(8'hFF);
      check("gap_valid", {127'b0, valid}, {127'b0, (i == 16)});
      if (i == 5 || i == 11) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          check("gap_hold_valid", {127'b0, valid}, 128'b0);
          check("gap_hold_out", out, (i == 5) ? GAP5 : GAP11);
        end
      end
    end
    check("gap_out", out, {128{1'b1}});
    idle(1);

    // clear mid-block, claer beats en
    for (int i = 0; i < 7; i++) send(8'h11);
    claer = 1'b1;
    en    = 1'b1;
    in    = 8'h22;
    tick();
    claer = 1'b0;
    en    = 1'b0;
    check("clr_mid_out", out, 128'b0);
    check("clr_mid_valid", {127'b0, valid}, 128'b0);
    for (int i = 1; i <= 16; i++) begin
      send(8'hA5);
      check("clr_a5_valid", {127'b0, valid}, {127'b0, (i == 16)});
    end
    check("clr_a5_out", out, {16{8'hA5}});
    idle(1);

    // back-to-back blocks with continuous en
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in = 8'(8'h10 + i);
      tick();
      check("b2b_valid", {127'b0, valid}, {127'b0, (i == 15 || i == 31)});
      if (i == 15) check("b2b_out1", out, B2B_1);
      if (i == 31) check("b2b_out2", out, B2B_2);
    end
    en = 1'b0;
    idle(1);

    // asynchronous reset mid-block
    for (int i = 0; i < 9; i++) send(8'h77);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", out, 128'b0);
    check("async_rst_valid", {127'b0, valid}, 128'b0);
    en = 1'b1;
    in = 8'h55;
    tick();
    check("rst_hold_out", out, 128'b0);
    en = 1'b0;
    #3;
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send(8'h3C);
      check("rst_3c_valid", {127'b0, valid}, {127'b0, (i == 16)});
    end
    check("rst_3c_out", out, {16{8'h3C}});
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_8to128.md
# sipo_8to128

Serial-in/parallel-out byte packer that collects sixteen 8-bit words into one 128-bit block. It sits at the front of the AES datapath. It turns a byte-wide input stream (plaintext or key bytes) into the 128-bit state word consumed by the cipher core, and flags each completed block with a one-cycle `valid` pulse.

## Interface
Parameters: none. Widths are fixed at 8-bit in and 128-bit out, with 16 bytes per block.

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: byte strobe; `in` is captured on a rising edge where `en`=1.
- `claer` input 1: synchronous clear of the partial block. The port name is spelled this way in the codebase and must be kept.
- `in` input 8: input byte.
- `valid` output 1: registered; high for exactly one cycle when the 16th byte of a block has been captured.
- `out` output 128: registered shift/assembly register holding the packed block.

## Operation
- Internal 4-bit byte counter `cnt` (0..15) and 128-bit register `out`.
- Priority per rising edge, highest first: `reset` (async), `claer`, `en`, idle.
- **`reset`=1:**
  - `out`=0, `cnt`=0, `valid`=0, immediately and independent of `clk`.
  - Holds while asserted, including mid-block. The partial block is discarded.
- **`claer`=1 at edge:**
  - `out`=0, `cnt`=0, `valid`=0.
  - `en` and `in` are ignored that cycle.
- **`en`=1, `claer`=0:**
  - `out` <= {`out`[119:0], `in`}, so the first byte of a block ends in `out`[127:120] and the 16th in `out`[7:0].
  - `cnt` <= `cnt`+1, wrapping 15->0.
  - `valid` <= (`cnt`==15).
- **`en`=0, `claer`=0:** `out` and `cnt` hold; `valid` <= 0.
- Gaps in `en` are allowed anywhere in a block; only strobed bytes count.
- After a wrap, the next strobed byte starts a new block. There is no back-pressure and no overflow condition.

## Timing
- Latency: `valid` rises on the same edge that captures byte 16. `out` holds the complete block during that `valid`-high cycle.
- `valid` is never high for two consecutive cycles, because 16 captures are needed between pulses.
- With continuous `en`, `out` shifts again on the next edge. Consumers must sample `out` while `valid`=1.
- `in` and `en` are sampled only at rising edges and need no hold beyond setup/hold.
- Reset deassertion: the first capture can occur on the first rising edge after `reset` falls.

## Configuration
- Macro `SIPO_LSB_FIRST_EN`.
- **Defined:** byte order is reversed. `out` <= {`in`, `out`[127:8]}, so the first byte of a block ends in `out`[7:0] and the 16th in `out`[127:120]. Counter, `valid`, `claer` and reset behaviour are unchanged.
- **Undefined (default):** MSB-first order as in Operation.

## Test plan
- **Reset:** `reset`=1 for 100 ns with `en`=0 -> `out`=0 and `valid`=0 throughout. Raising `reset` asynchronously mid-cycle zeroes `out` without waiting for a clock edge.
- **Full block:** after reset, `en`=1 for 16 consecutive edges with `in`=0x00,0x01,...,0x0F.
  - `valid`=1 only in the cycle after edge 16.
  - `out`=128'h000102030405060708090A0B0C0D0E0F.
  - With `SIPO_LSB_FIRST_EN`: `out`=128'h0F0E0D0C0B0A09080706050403020100.
- **Gapped strobes:** send 16 bytes of 0xFF, with `en` low for 3 cycles after byte 5 and again after byte 11. `valid` pulses once, only after byte 16, and `out`=all ones. `out` is unchanged during the gaps.
- **Clear mid-block:**
  - Capture 7 bytes, then assert `claer`=1 together with `en`=1 for one edge -> `out`=0, no `valid`.
  - Next, send 16 bytes 0xA5 -> `valid` pulses after exactly 16 further captures, with `out`=0xA5 repeated.
- **Back-to-back blocks:** continuous `en` for 32 edges with `in`=0x10..0x2F.
  - `valid` pulses after edge 16 with `out`=128'h101112...1F, and after edge 32 with `out`=128'h202122...2F.
  - `valid` is low on all other cycles.
- **Reset mid-block:** 9 bytes captured, then pulse `reset`, then 16 bytes 0x3C -> a single `valid`, with `out`=0x3C repeated. No bytes from before the reset appear in `out`.
